// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands one CHUNK-bit slice per clock, LSB first.
// Subtraction is enabled by defining MULTICYCLE_ADDER_SUB_EN; otherwise the block is add-only.
module multicycle_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST       = CW'(N - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [WIDTH-1:0] opb_in;
    logic             carry_in;

`ifdef MULTICYCLE_ADDER_SUB_EN
    assign opb_in   = b ^ {WIDTH{sub}};
    assign carry_in = sub;
`else
    logic unused_sub;
    assign opb_in     = b;
    assign carry_in   = 1'b0;
    assign unused_sub = sub;
`endif

    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh, b_sh, sum_merged;
    logic [CHUNK-1:0] sa, sb, ss;
    logic [CHUNK:0]   res;
    logic             msb_cin;

    // Shifts rather than variable part-selects keep the slice mux width-clean for any CHUNK.
    always_comb begin
        base       = 32'(cnt_q) * CHUNK;
        a_sh       = opa_q >> base;
        b_sh       = opb_q >> base;
        sa         = a_sh[CHUNK-1:0];
        sb         = b_sh[CHUNK-1:0];
        res        = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, carry_q};
        ss         = res[CHUNK-1:0];
        msb_cin    = sa[CHUNK-1] ^ sb[CHUNK-1] ^ ss[CHUNK-1];
        sum_merged = (sum_q & ~(SLICE_MASK << base)) | (WIDTH'(ss) << base);
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = opb_in;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = sum_merged;
                carry_d = res[CHUNK];
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = res[CHUNK];
                    ovf_d   = msb_cin ^ res[CHUNK];
                    zero_d  = (sum_merged == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder: directed handshake/flag scenarios on CHUNK=8 plus
// a randomized sweep across CHUNK in {8,1,4,32} against an arithmetic reference model.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst_n, start, sub;
    logic [31:0] a, b;
    logic        busy_w [4];
    logic        done_w [4];
    logic        cout_w [4];
    logic        ovf_w  [4];
    logic        zero_w [4];
    logic [31:0] sum_w  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int unsigned chunk_of(int i);
        case (i)
            0:       return 8;
            1:       return 1;
            2:       return 4;
            default: return 32;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        multicycle_adder #(.WIDTH(32), .CHUNK(chunk_of(g))) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
            .busy(busy_w[g]), .done(done_w[g]), .sum(sum_w[g]),
            .cout(cout_w[g]), .ovf(ovf_w[g]), .zero(zero_w[g])
        );
    end

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    // Reference: true integer result, then derive the flags from its meaning.
    function automatic res_t model(logic [31:0] x, logic [31:0] y, logic s);
        res_t   r;
        logic   eff;
        longint sres;
`ifdef MULTICYCLE_ADDER_SUB_EN
        eff = s;
`else
        eff = 1'b0;
`endif
        if (eff) begin
            r.s  = x - y;
            r.c  = (x >= y);
            sres = longint'($signed(x)) - longint'($signed(y));
        end else begin
            r.s  = x + y;
            r.c  = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
            sres = longint'($signed(x)) + longint'($signed(y));
        end
        r.v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        r.z = (r.s == 32'd0);
        return r;
    endfunction

    // Drives one operation into the CHUNK=8 instance; returns latency (-1 on timeout).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        a = ta; b = tbv; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done_w[0] && lat < 64) begin
            if (!busy_w[0]) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!done_w[0]) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy_w[i], done_w[i], sum_w[i], cout_w[i], ovf_w[i], zero_w[i]} !== 37'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b sum=%h c=%b v=%b z=%b, expected all 0",
                         i, busy_w[i], done_w[i], sum_w[i], cout_w[i], ovf_w[i], zero_w[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(string name, logic [31:0] ta, logic [31:0] tbv, logic ts,
                            logic [31:0] es, logic ec, logic ev, logic ez);
        int lat;
        bit busy_ok;
        run_op(ta, tbv, ts, lat, busy_ok);
        n_checks++;
        if (lat !== 5 || !busy_ok || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timing: got latency=%0d busy_ok=%b busy_at_done=%b, expected 5/1/0",
                     name, lat, busy_ok, busy_w[0]);
        end
        n_checks++;
        if ({sum_w[0], cout_w[0], ovf_w[0], zero_w[0]} !== {es, ec, ev, ez}) begin
            n_fail++;
            $display("FAIL %s_result: got sum=%h c=%b v=%b z=%b, expected sum=%h c=%b v=%b z=%b",
                     name, sum_w[0], cout_w[0], ovf_w[0], zero_w[0], es, ec, ev, ez);
        end
    endtask

    task automatic test_add();
        check_op("add_carry_slice", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 0, 0, 0);
        check_op("add_overflow",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0);
        check_op("add_wrap_zero",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 1);
    endtask

    task automatic test_sub();
`ifdef MULTICYCLE_ADDER_SUB_EN
        check_op("sub_borrow", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
        check_op("sub_equal",  32'd7, 32'd7, 1'b1, 32'h0000_0000, 1, 0, 1);
`else
        check_op("sub_ignored",   32'd5, 32'd7, 1'b1, 32'd12, 0, 0, 0);
        check_op("sub_ignored_2", 32'd7, 32'd7, 1'b1, 32'd14, 0, 0, 0);
`endif
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        a = 32'h0000_00FF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (!done_w[0] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 5 || sum_w[0] !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got done_cycle=%0d sum=%h, expected 5 and 00000100", cyc, sum_w[0]);
        end
        a = 32'd2; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        n_checks++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b busy=%b, expected 0 1", done_w[0], busy_w[0]);
        end
        while (!done_w[0] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 5 || sum_w[0] !== 32'd5) begin
            n_fail++;
            $display("FAIL start_in_done: got latency=%0d sum=%h, expected 5 and 00000005", cyc, sum_w[0]);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        bit busy_ok;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_w[0], done_w[0], sum_w[0], cout_w[0], ovf_w[0], zero_w[0]} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b done=%b sum=%h c=%b v=%b z=%b, expected all 0",
                     busy_w[0], done_w[0], sum_w[0], cout_w[0], ovf_w[0], zero_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_w[0]) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL aborted_no_done: got %0d done pulses, expected 0", pulses);
        end
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, lat, busy_ok);
        n_checks++;
        if (lat !== 5 || sum_w[0] !== 32'h0000_0030) begin
            n_fail++;
            $display("FAIL after_reset_op: got latency=%0d sum=%h, expected 5 and 00000030", lat, sum_w[0]);
        end
    endtask

    task automatic test_sweep();
        int   lat [4];
        res_t got [4];
        bit   seen [4];
        res_t exp_r;
        int   cyc;
        bit   all;
        for (int it = 0; it < 24; it++) begin
            cyc = 0;
            while ((busy_w[0] || busy_w[1] || busy_w[2] || busy_w[3]) && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            if (it == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; end
            if (it == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; end
            exp_r = model(a, b, sub);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a = ~a; b = $urandom; sub = ~sub;
            for (int i = 0; i < 4; i++) begin lat[i] = -1; seen[i] = 1'b0; got[i] = '0; end
            cyc = 1;
            all = 1'b0;
            while (!all && cyc <= 40) begin
                all = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (!seen[i] && done_w[i]) begin
                        seen[i] = 1'b1;
                        lat[i]  = cyc;
                        got[i]  = '{s: sum_w[i], c: cout_w[i], v: ovf_w[i], z: zero_w[i]};
                    end
                    all &= seen[i];
                end
                if (!all) begin
                    @(negedge clk);
                    cyc++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (lat[i] !== int'(32 / chunk_of(i)) + 1) begin
                    n_fail++;
                    $display("FAIL sweep_latency chunk=%0d it=%0d: got %0d, expected %0d",
                             chunk_of(i), it, lat[i], 32 / chunk_of(i) + 1);
                end
                n_checks++;
                if (got[i] !== exp_r) begin
                    n_fail++;
                    $display("FAIL sweep_result chunk=%0d it=%0d: got sum=%h c=%b v=%b z=%b, expected sum=%h c=%b v=%b z=%b",
                             chunk_of(i), it, got[i].s, got[i].c, got[i].v, got[i].z,
                             exp_r.s, exp_r.c, exp_r.v, exp_r.z);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised, multi-cycle successor to the team's 32-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, LSB slice first. A registered carry chains the slices, which keeps the combinational carry path at CHUNK bits. The block sits beside the ALU in the multicycle datapath and is driven by the control FSM through a start/done handshake. It returns sum, carry, signed-overflow and zero flags.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK must be 0, and 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0 = A+B, 1 = A−B. Sampled with start.
- a  input  WIDTH  operand A. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry out of the MSB. For subtraction, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE or DONE, with start=1:**
  - Latch a into opA.
  - Latch b XOR {WIDTH{sub}} into opB.
  - Set carry register to sub.
  - Clear slice counter to 0.
  - Go to RUN.
- **IDLE or DONE, with start=0:** DONE → IDLE; IDLE stays IDLE.
- **RUN, each cycle:**
  - slice k = counter.
  - {c, s} = opA[k] + opB[k] + carry, where opA[k] and opB[k] are CHUNK-bit slices.
  - Write s into sum[k*CHUNK +: CHUNK].
  - carry ← c.
  - Counter increments.
  - On the last slice (k = N−1), go to DONE and update the flags from that slice.
- **Flags:**
  - cout = final carry.
  - ovf = carry into the MSB XOR carry out of the MSB, taken from the MSB bit position of the last slice.
  - zero = (full sum == 0), evaluated with the final slice merged in.
- **start while busy=1:** ignored, with no effect on operands or progress.
- **Result hold:** sum and the flags hold their values until the next accepted start. On an accepted start, sum clears to 0 and the flags clear.
- **Operand stability:** operands are captured at start; changes on a, b or sub during RUN have no effect.
- **Counter width:** $clog2(N) bits, minimum 1. It never wraps past N−1.
- **CHUNK = WIDTH (N = 1):** RUN lasts one cycle.

## Timing
- **Reset values** (async assert, sync-to-clk deassert behaviour handled upstream):
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0, zero=0.
  - Internal: state=IDLE, counter=0, carry=0.
- **Latency:** start is high in cycle 0 with busy=0.
  - busy=1 in cycles 1..N.
  - done=1 in cycle N+1, with busy=0 and all results valid.
- **Back-to-back:** start may be asserted in the DONE cycle. It is accepted, and busy rises next cycle, so throughput is one operation per N+1 cycles.
- **done:** high for exactly one cycle per accepted start.
- **Reset mid-operation:** rst_n low at any point forces the reset values immediately. No done pulse is produced for the aborted operation.

## Configuration
- Macro: MULTICYCLE_ADDER_SUB_EN.
- **Defined:** sub behaves as specified.
- **Undefined:**
  - The sub port remains but is ignored.
  - opB = b and the initial carry = 0, so the block is add-only.
  - The XOR inversion logic is not synthesised.

## Test plan
1. WIDTH=32, CHUNK=8, a=0x0000_00FF, b=0x0000_0001, sub=0 → busy high cycles 1–4; done in cycle 5; sum=0x0000_0100, cout=0, ovf=0, zero=0. Confirms carry propagates across the slice boundary.
2. a=0x7FFF_FFFF, b=0x0000_0001, add → sum=0x8000_0000, ovf=1, cout=0. Then a=0xFFFF_FFFF, b=0x0000_0001 → sum=0, cout=1, zero=1, ovf=0.
3. MULTICYCLE_ADDER_SUB_EN defined, a=5, b=7, sub=1 → sum=0xFFFF_FFFE, cout=0 (borrow). Then a=7, b=7, sub=1 → sum=0, zero=1, cout=1. Rerun with the macro undefined: a=5, b=7, sub=1 → sum=12.
4. Handshake: assert start again in cycle 2 with a=1, b=1 → ignored, first result unchanged. Assert start in the DONE cycle with a=2, b=3 → accepted; done exactly 5 cycles later; sum=5.
5. Pull rst_n low in cycle 2 of an operation → all outputs 0 immediately. Release rst_n, wait 10 cycles → no done pulse. Then a new start completes normally.
6. Parameter sweep over CHUNK ∈ {1, 4, 32} with WIDTH=32, random a/b/sub versus a reference model → latency is N+1 cycles and sum and all flags match.
